seg7_scan_driver: RTL

//  Reader side of the stopwatch BCD bus: takes the four BCD digits (one/ten/hun/thoud)

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment glyph constants and the BCD-to-segment function for the
// stopwatch display path. Glyphs are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  // Codes 10-15 are not valid BCD and render as a lone middle bar.
  function automatic seg_t bcd_to_seg(input bcd_t d);
    seg_t s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high segment pattern decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with frame-coherent shadow latch and a
// per-slot guard cycle. Optional leading-zero blanking via LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 4,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
)(
  input  logic       msclk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] one,
  input  logic [3:0] ten,
  input  logic [3:0] hun,
  input  logic [3:0] thoud,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int          PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0]  AN_OFF   = AN_ACT_LOW ? 4'hF : 4'h0;
  localparam seg_t        SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic        DP_OFF   = SEG_ACT_LOW;

  logic [PW-1:0] r_p;
  logic [1:0]    r_i;
  bcd_t          r_sh [4];
  logic [3:0]    r_shDp;
  logic          r_frame;
  logic [3:0]    r_an;
  seg_t          r_seg;
  logic          r_dp;

  logic          w_last;
  logic [3:0]    w_onehot;
  seg_t          w_glyph;
  logic          w_blank;
  logic [3:0]    w_anNext;
  seg_t          w_segNext;
  logic          w_dpNext;

  assign w_last   = (r_p == P_LAST);
  assign w_onehot = 4'b0001 << r_i;

  seg7_decode u_decode (
    .i_bcd (r_sh[r_i]),
    .o_seg (w_glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blanking looks only at the shadow so a digit never blanks mid-frame.
  always_comb begin
    w_blank = 1'b0;
    case (r_i)
      2'd3:    w_blank = (r_sh[3] == 4'd0);
      2'd2:    w_blank = (r_sh[3] == 4'd0) && (r_sh[2] == 4'd0);
      2'd1:    w_blank = (r_sh[3] == 4'd0) && (r_sh[2] == 4'd0) && (r_sh[1] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  // The last prescaler count of every slot is a dark guard cycle against ghosting.
  always_comb begin
    w_anNext  = AN_OFF;
    w_segNext = SEG_IDLE;
    w_dpNext  = DP_OFF;
    if (en && !w_last) begin
      w_anNext  = AN_ACT_LOW ? ~w_onehot : w_onehot;
      w_segNext = w_blank ? SEG_IDLE : (SEG_ACT_LOW ? ~w_glyph : w_glyph);
      w_dpNext  = r_shDp[r_i] ^ DP_OFF;
    end
  end

  always_ff @(posedge msclk or posedge reset) begin
    if (reset) begin
      r_p     <= '0;
      r_i     <= 2'd0;
      r_shDp  <= 4'd0;
      r_frame <= 1'b0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_IDLE;
      r_dp    <= DP_OFF;
      for (int k = 0; k < 4; k++) r_sh[k] <= 4'd0;
    end else begin
      r_frame <= w_last && (r_i == 2'd3);
      r_an    <= w_anNext;
      r_seg   <= w_segNext;
      r_dp    <= w_dpNext;
      if (w_last) begin
        r_p <= '0;
        r_i <= r_i + 2'd1;
        // Whole-frame snapshot keeps all four digits from the same count value.
        if (r_i == 2'd3) begin
          r_sh[0] <= one;
          r_sh[1] <= ten;
          r_sh[2] <= hun;
          r_sh[3] <= thoud;
          r_shDp  <= dp_in;
        end
      end else begin
        r_p <= r_p + PW'(1);
      end
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = r_dp;
  assign frame = r_frame;

endmodule
